// File: rtl/det_pkg.sv
// Shared types and default sizing for the window counter and detector bench.
package det_pkg;

  localparam int unsigned WIN_LEN_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/det_out_reg.sv
// Result holding register: valid/ready output stage with a sticky overrun flag.
module det_out_reg #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_count,
  input  logic             clr_ovr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overrun
);

  logic slot_free;
  logic drop;

  // A handshake in the same cycle frees the slot for the incoming result.
  assign slot_free = !out_valid || out_ready;
  assign drop      = load && !slot_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_count   <= '0;
      out_overrun <= 1'b0;
    end else begin
      if (load && slot_free) begin
        out_valid <= 1'b1;
        out_count <= load_count;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop) begin
        out_overrun <= 1'b1;
      end else if (clr_ovr) begin
        out_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/det_window_counter.sv
// Counts detector pulses over fixed windows of accepted serial bits and
// hands each window's count to a valid/ready output register.
module det_window_counter
  import det_pkg::*;
#(
  parameter int unsigned WIN_LEN = WIN_LEN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             det,
  input  logic             clr_ovr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIN_LEN - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0] det_cnt, det_cnt_nxt;
  logic [CNT_W-1:0] win_count;
  logic             accept;
  logic             win_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      det_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      det_cnt <= det_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    det_cnt_nxt = det_cnt;
    accept      = 1'b0;
    win_done    = 1'b0;
    win_count   = det_cnt + CNT_W'(det);

    case (state)
      S_IDLE:  accept = en && in_valid;
      S_COUNT: begin
        if (!en) begin
          state_nxt   = S_IDLE;
          bit_cnt_nxt = '0;
          det_cnt_nxt = '0;
        end else begin
          accept = in_valid;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Completion restarts at bit 0 while staying in S_COUNT, so windows abut.
    if (accept) begin
      state_nxt = S_COUNT;
      if (bit_cnt == LAST_BIT) begin
        win_done    = 1'b1;
        bit_cnt_nxt = '0;
        det_cnt_nxt = '0;
      end else begin
        bit_cnt_nxt = bit_cnt + CNT_W'(1);
        det_cnt_nxt = win_count;
      end
    end
  end

  det_out_reg #(
    .CNT_W(CNT_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (win_done),
    .load_count (win_count),
    .clr_ovr    (clr_ovr),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_count  (out_count),
    .out_overrun(out_overrun)
  );

endmodule

// File: tb/tb_det_window_counter.sv
// Directed bench for det_window_counter: expected window counts are queued by
// the driver and checked by a monitor on each output handshake.
module tb_det_window_counter;
  import det_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, in_valid, det, clr_ovr, out_ready;
  logic       out_valid, out_overrun;
  logic [3:0] out_count;

  int vectors     = 0;
  int miscompares = 0;
  logic mon_en    = 1'b0;
  int unsigned exp_q[$];

  det_window_counter #(
    .WIN_LEN(8),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .det        (det),
    .clr_ovr    (clr_ovr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_overrun(out_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a result is consumed whenever valid and ready meet.
  always @(negedge clk) begin
    if (mon_en && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_count), 32'hFFFF_FFFF);
      end else begin
        chk("result_count", 32'(out_count), exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic d);
    in_valid = v;
    det      = d;
    @(posedge clk);
    #1;
  endtask

  // Eight contiguous accepted bits, bits[0] first; ready/clr applied on the last.
  task automatic win(input logic [7:0] bits, input logic last_rdy, input logic last_clr);
    for (int i = 0; i < 7; i++) step(1'b1, bits[i]);
    out_ready = last_rdy;
    clr_ovr   = last_clr;
    step(1'b1, bits[7]);
    clr_ovr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; det = 1'b0; clr_ovr = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    // Reset dominates random inputs
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); clr_ovr = 1'($urandom); out_ready = 1'($urandom);
      step(1'($urandom), 1'($urandom));
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_count", 32'(out_count), 0);
      chk("rst_overrun", 32'(out_overrun), 0);
    end
    rst = 1'b0; en = 1'b0; clr_ovr = 1'b0; out_ready = 1'b1;
    step(1'b0, 1'b0);
    mon_en = 1'b1;

    // Single window 0,1,1,0,0,1,0,1 -> 4, visible right after the 8th edge
    en = 1'b1;
    exp_q.push_back(4);
    for (int i = 0; i < 7; i++) step(1'b1, (i == 1 || i == 2 || i == 5) ? 1'b1 : 1'b0);
    chk("no_early_valid", 32'(out_valid), 0);
    step(1'b1, 1'b1);
    chk("win1_valid", 32'(out_valid), 1);
    chk("win1_count", 32'(out_count), 4);
    step(1'b0, 1'b0);
    chk("win1_consumed", 32'(out_valid), 0);

    // Back-to-back windows: 4 then 8
    exp_q.push_back(4);
    exp_q.push_back(8);
    win(8'hA6, 1'b1, 1'b0);
    win(8'hFF, 1'b1, 1'b0);
    chk("b2b_count", 32'(out_count), 8);
    step(1'b0, 1'b0);
    chk("b2b_overrun", 32'(out_overrun), 0);

    // Stalled consumer: second result dropped, overrun sticky
    out_ready = 1'b0;
    exp_q.push_back(4);
    win(8'hA6, 1'b0, 1'b0);
    win(8'hFF, 1'b0, 1'b0);
    chk("stall_valid", 32'(out_valid), 1);
    chk("stall_count", 32'(out_count), 4);
    chk("stall_overrun", 32'(out_overrun), 1);
    clr_ovr = 1'b1; step(1'b0, 1'b0); clr_ovr = 1'b0;
    chk("clr_overrun", 32'(out_overrun), 0);

    // Clear coinciding with a new drop leaves overrun set
    win(8'hFF, 1'b0, 1'b1);
    chk("clr_vs_drop_overrun", 32'(out_overrun), 1);
    chk("clr_vs_drop_count", 32'(out_count), 4);
    clr_ovr = 1'b1; step(1'b0, 1'b0); clr_ovr = 1'b0;
    chk("clr_overrun2", 32'(out_overrun), 0);

    // Completion during handshake: held 4 consumed, new 3 loaded, no overrun
    exp_q.push_back(3);
    win(8'h07, 1'b1, 1'b0);
    chk("hs_load_valid", 32'(out_valid), 1);
    chk("hs_load_count", 32'(out_count), 3);
    chk("hs_load_overrun", 32'(out_overrun), 0);
    step(1'b0, 1'b0);
    chk("hs_load_consumed", 32'(out_valid), 0);

    // Detections on non-accepted cycles are ignored
    exp_q.push_back(0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
    end
    chk("gap_det_valid", 32'(out_valid), 0);

    // Abort after 5 bits, then a full window of three ones
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    en = 1'b0;
    step(1'b1, 1'b1);
    chk("abort_no_result", 32'(out_valid), 0);
    en = 1'b1;
    exp_q.push_back(3);
    win(8'h07, 1'b1, 1'b0);
    chk("after_abort_count", 32'(out_count), 3);
    step(1'b0, 1'b0);

    // Reset mid-window discards partial count
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 0);
    exp_q.push_back(2);
    win(8'h81, 1'b1, 1'b0);
    chk("midrst_count", 32'(out_count), 2);
    step(1'b0, 1'b0);

    begin
      int budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        step(1'b0, 1'b0);
        budget--;
      end
    end
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("final_overrun", 32'(out_overrun), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/det_window_counter.md
DET_WINDOW_COUNTER -- requirements
Module: det_window_counter

Interface
REQ-001 SHALL have parameter WIN_LEN, default 8: number of accepted input bits per window.
REQ-002 SHALL have parameter CNT_W, default 4: count width, SHALL satisfy CNT_W >= clog2(WIN_LEN+1).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  window counting enable.
REQ-006 SHALL have port in_valid  input  1  qualifies det for the current cycle (one serial bit accepted).
REQ-007 SHALL have port det  input  1  detection pulse y from the upstream 111/000 Mealy detector.
REQ-008 SHALL have port clr_ovr  input  1  clears sticky overrun flag.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_count  output  CNT_W  detections in the completed window.
REQ-012 SHALL have port out_overrun  output  1  sticky: a completed window result was dropped.

Function
REQ-013 SHALL implement FSM states S_IDLE and S_COUNT; reset state S_IDLE.
REQ-014 S_IDLE -> S_COUNT on en=1 and in_valid=1; that bit is window bit 0 and SHALL be counted.
REQ-015 In S_COUNT, each cycle with in_valid=1 SHALL increment bit_cnt and add det to det_cnt; cycles with in_valid=0 SHALL change nothing, regardless of det.
REQ-016 On the accepted bit with bit_cnt = WIN_LEN-1 the window completes; final count = det_cnt + det.
REQ-017 At completion bit_cnt and det_cnt SHALL return to 0 and FSM SHALL remain in S_COUNT if en=1: back-to-back windows, no gap bit.
REQ-018 Result latency: out_valid and out_count SHALL update on the clock edge that accepts the last bit (visible the following cycle).
REQ-019 out_valid SHALL stay 1, out_count stable, until a cycle with out_valid=1 and out_ready=1; then out_valid SHALL clear.
REQ-020 Completion while out_valid=1 and out_ready=0: new result SHALL be dropped, held result kept, out_overrun set to 1.
REQ-021 Completion in the same cycle as a handshake (out_valid=1, out_ready=1): new result SHALL be loaded, out_valid stays 1, no overrun.
REQ-022 en=0 in S_COUNT: partial window SHALL be aborted, counters cleared, FSM -> S_IDLE, no result produced; held output unaffected.
REQ-023 out_overrun SHALL stay 1 until clr_ovr=1 or rst; simultaneous clr_ovr and new overrun SHALL leave out_overrun=1.
REQ-024 det_cnt never exceeds WIN_LEN; no saturation logic SHALL be added.

Reset
REQ-025 rst=1 SHALL force S_IDLE, bit_cnt=0, det_cnt=0, out_valid=0, out_count=0, out_overrun=0, overriding all other inputs that cycle.
REQ-026 rst mid-window SHALL discard the partial window; the next window starts from bit 0 after rst deasserts.

Structure
REQ-027 Package det_pkg SHALL hold the FSM state typedef and default WIN_LEN/CNT_W constants, shared with the detector bench.
REQ-028 Output holding register with valid/ready and overrun logic SHALL be sub-module det_out_reg; counters and FSM stay in the top.

Verification (WIN_LEN=8, CNT_W=4)
REQ-029 rst=1 for 2 cycles with random inputs -> out_valid=0, out_count=0, out_overrun=0.
REQ-030 en=1, out_ready=1, 8 contiguous bits det=0,1,1,0,0,1,0,1 -> out_valid=1 one cycle after 8th bit edge, out_count=4.
REQ-031 Two back-to-back windows, second all det=1, out_ready=1 -> results 4 then 8, no gap, out_overrun=0.
REQ-032 out_ready=0 across two completions (counts 4, 8) -> out_count held at 4, out_overrun=1; clr_ovr pulse -> out_overrun=0.
REQ-033 in_valid toggling 1/0 with det=1 on every in_valid=0 cycle, det=0 on accepted bits -> out_count=0 after 8 accepted bits.
REQ-034 en dropped after 5 accepted bits, then a full window of 3 ones -> only one result, out_count=3.
